// File: rtl/alu_seq_mdu.sv
// alu_seq_mdu: registered ALU with an iterative multiply/divide unit.
// Single-cycle ALU ops; shift-add MULT/MULTU and restoring DIV/DIVU, one bit per cycle.
// Build option: define ALU_DIV_EN to include the divider; without it, DIV/DIVU decode as illegal ops.
// The final MDU step and the output load share one edge, so the DONE cycle is the
// cycle in which the result is first presented.
module alu_seq_mdu #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow,
    output logic             err
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    localparam int               M        = WIDTH - 1;
    localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;     // MUL: product high half; DIV: partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;       // MUL: multiplier/product low; DIV: dividend/quotient
    logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic             sgn_q, sgn_d;     // signed variant in flight
    logic             rneg_q, rneg_d;   // product/quotient must be negated
`ifdef ALU_DIV_EN
    logic             aneg_q, aneg_d;   // remainder takes the sign of a
    logic             ovf_q, ovf_d;     // MIN / -1
    logic             div0_q, div0_d;   // divide by zero: skip iterations
`endif
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] r_q, r_d, hi_q, hi_d;
    logic             zero_q, zero_d, carry_q, carry_d, negative_q, negative_d;
    logic             overflow_q, overflow_d, err_q, err_d;

    logic             accept;
    assign in_ready = !rst && (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle ALU result and flags from the raw inputs
    logic [WIDTH-1:0] alu_r;
    logic             alu_z, alu_c, alu_n, alu_v, lt_s, lt_u;
    logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w, sra_w;
    logic [SHW-1:0]   sh;
    always_comb begin
        sh    = a[SHW-1:0];
        add_w = {1'b0, a} + {1'b0, b};
        sub_w = {1'b0, a} - {1'b0, b};
        lt_u  = sub_w[WIDTH];
        lt_s  = $signed(a) < $signed(b);
        // One spare bit on the far side of each shift catches the last bit shifted out
        shl_w = {1'b0, b} << sh;
        shr_w = {b, 1'b0} >> sh;
        sra_w = $signed({b, 1'b0}) >>> sh;
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        casez (op[3:0])
            4'b0000: begin alu_r = add_w[M:0]; alu_c = add_w[WIDTH]; end
            4'b0010: begin alu_r = add_w[M:0]; alu_v = (a[M] == b[M]) && (alu_r[M] != a[M]); end
            4'b0001: begin alu_r = sub_w[M:0]; alu_c = lt_u; end
            4'b0011: begin alu_r = sub_w[M:0]; alu_v = (a[M] != b[M]) && (alu_r[M] != a[M]); end
            4'b0100: alu_r = a & b;
            4'b0101: alu_r = a | b;
            4'b0110: alu_r = a ^ b;
            4'b0111: alu_r = ~(a | b);
            4'b100?: alu_r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            4'b1010: begin alu_r = {{M{1'b0}}, lt_u}; alu_c = lt_u; end
            4'b1011: alu_r = {{M{1'b0}}, lt_s};
            4'b1100: begin alu_r = sra_w[WIDTH:1]; alu_c = sra_w[0]; end
            4'b1101: begin alu_r = shr_w[WIDTH:1]; alu_c = shr_w[0]; end
            default: begin alu_r = shl_w[M:0]; alu_c = shl_w[WIDTH]; end
        endcase
        alu_z = (alu_r == '0);
        alu_n = alu_r[M];
        if (op[3:1] == 3'b101) alu_z = (a == b);
        if (op[3:0] == 4'b1011) alu_n = lt_s;
    end

    // One MDU iteration: shift-add for MUL, restore-or-keep trial subtract for DIV
    logic [WIDTH:0]   mul_sum, step_acc;
    logic [WIDTH-1:0] step_lo;
`ifdef ALU_DIV_EN
    logic [WIDTH:0]   div_sh;
    logic [WIDTH+1:0] div_diff;
`endif
    always_comb begin
        mul_sum  = acc_q + (lo_q[0] ? {1'b0, opnd_q} : '0);
        step_acc = {1'b0, mul_sum[WIDTH:1]};
        step_lo  = {mul_sum[0], lo_q[M:1]};
`ifdef ALU_DIV_EN
        div_sh   = {acc_q[M:0], lo_q[M]};
        div_diff = {1'b0, div_sh} - {2'b0, opnd_q};
        if (state_q == S_DIV) begin
            if (!div_diff[WIDTH+1]) begin
                step_acc = div_diff[WIDTH:0];
                step_lo  = {lo_q[M-1:0], 1'b1};
            end else begin
                step_acc = div_sh;
                step_lo  = {lo_q[M-1:0], 1'b0};
            end
        end
`endif
    end

    // Sign-corrected results from the final iteration
    logic [2*WIDTH-1:0] prod;
`ifdef ALU_DIV_EN
    logic [WIDTH-1:0]   quo, rem;
`endif
    always_comb begin
        prod = {step_acc[M:0], step_lo};
        if (rneg_q) prod = -prod;
`ifdef ALU_DIV_EN
        quo = rneg_q ? -step_lo : step_lo;
        rem = aneg_q ? -step_acc[M:0] : step_acc[M:0];
`endif
    end

    // FSM next state, MDU datapath and output register loads
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        lo_d        = lo_q;
        opnd_d      = opnd_q;
        sgn_d       = sgn_q;
        rneg_d      = rneg_q;
`ifdef ALU_DIV_EN
        aneg_d      = aneg_q;
        ovf_d       = ovf_q;
        div0_d      = div0_q;
`endif
        out_valid_d = out_valid_q && !out_ready;
        r_d         = r_q;
        hi_d        = hi_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        negative_d  = negative_q;
        overflow_d  = overflow_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // MDU operands are latched as magnitudes; sign fixed up at the end
                    cnt_d  = CNT_LAST;
                    acc_d  = '0;
                    lo_d   = (op[0] && a[M]) ? -a : a;
                    opnd_d = (op[0] && b[M]) ? -b : b;
                    sgn_d  = op[0];
                    rneg_d = op[0] && (a[M] ^ b[M]);
                    if (!op[4]) begin
                        out_valid_d = 1'b1;
                        r_d         = alu_r;
                        hi_d        = '0;
                        zero_d      = alu_z;
                        carry_d     = alu_c;
                        negative_d  = alu_n;
                        overflow_d  = alu_v;
                        err_d       = 1'b0;
                    end else if (op[3:1] == 3'b000) begin
                        state_d = S_MUL;
`ifdef ALU_DIV_EN
                    end else if (op[3:1] == 3'b001) begin
                        state_d = S_DIV;
                        aneg_d  = op[0] && a[M];
                        ovf_d   = op[0] && (a == {1'b1, {M{1'b0}}}) && (b == '1);
                        div0_d  = (b == '0);
                        if (b == '0) lo_d = a;
`endif
                    end else begin
                        out_valid_d = 1'b1;
                        r_d         = '0;
                        hi_d        = '0;
                        zero_d      = 1'b0;
                        carry_d     = 1'b0;
                        negative_d  = 1'b0;
                        overflow_d  = 1'b0;
                        err_d       = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d = step_acc;
                lo_d  = step_lo;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    r_d         = prod[M:0];
                    hi_d        = prod[2*WIDTH-1:WIDTH];
                    zero_d      = (prod == '0);
                    carry_d     = 1'b0;
                    negative_d  = sgn_q && prod[2*WIDTH-1];
                    overflow_d  = 1'b0;
                    err_d       = 1'b0;
                end
            end
`ifdef ALU_DIV_EN
            S_DIV: begin
                if (div0_q) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    r_d         = '1;
                    hi_d        = lo_q;
                    zero_d      = 1'b0;
                    carry_d     = 1'b0;
                    negative_d  = 1'b0;
                    overflow_d  = 1'b0;
                    err_d       = 1'b1;
                end else begin
                    acc_d = step_acc;
                    lo_d  = step_lo;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        r_d         = quo;
                        hi_d        = rem;
                        zero_d      = (quo == '0);
                        carry_d     = 1'b0;
                        negative_d  = sgn_q && quo[M];
                        overflow_d  = ovf_q;
                        err_d       = 1'b0;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, synchronous reset clears everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            sgn_q       <= 1'b0;
            rneg_q      <= 1'b0;
`ifdef ALU_DIV_EN
            aneg_q      <= 1'b0;
            ovf_q       <= 1'b0;
            div0_q      <= 1'b0;
`endif
            out_valid_q <= 1'b0;
            r_q         <= '0;
            hi_q        <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            negative_q  <= 1'b0;
            overflow_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            lo_q        <= lo_d;
            opnd_q      <= opnd_d;
            sgn_q       <= sgn_d;
            rneg_q      <= rneg_d;
`ifdef ALU_DIV_EN
            aneg_q      <= aneg_d;
            ovf_q       <= ovf_d;
            div0_q      <= div0_d;
`endif
            out_valid_q <= out_valid_d;
            r_q         <= r_d;
            hi_q        <= hi_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            negative_q  <= negative_d;
            overflow_q  <= overflow_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign r         = r_q;
    assign hi        = hi_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign negative  = negative_q;
    assign overflow  = overflow_q;
    assign err       = err_q;
endmodule
